// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package display_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_STORE,
    ST_DONE
  } state_e;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] n);
    logic [6:0] s;
    s = SEG_DASH;
    for (int i = 0; i < 10; i++) begin
      if (n == 4'(i)) s = SEG_DIGIT[i];
    end
    return s;
  endfunction

  // Decimal digit count of 2^width-1
  function automatic int ndig(input int width);
    logic [63:0] v;
    int          n;
    v = (64'd1 << width) - 64'd1;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      if (v >= 64'd10) begin
        v = v / 64'd10;
        n = n + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_dd_converter.sv
// Iterative double-dabble engine: one load cycle, then IN_WIDTH step cycles.
// last_o flags the step that completes the conversion.
module dd_converter
  import display_pkg::*;
#(
  parameter int IN_WIDTH = 6,
  localparam int BCD_W = ndig(IN_WIDTH) * 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic                step_i,
  input  logic [IN_WIDTH-1:0] val_i,
  output logic [BCD_W-1:0]    bcd_o,
  output logic                last_o
);

  localparam int CNT_W = $clog2(IN_WIDTH + 1);

  logic [IN_WIDTH-1:0] sh_q, sh_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d, adj;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
    sh_d  = sh_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sh_d  = val_i;
      bcd_d = '0;
      cnt_d = CNT_W'(IN_WIDTH);
    end else if (step_i) begin
      // Add-3 correction and the shift happen in the same cycle
      bcd_d = {adj[BCD_W-2:0], sh_q[IN_WIDTH-1]};
      sh_d  = sh_q << 1;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign bcd_o  = bcd_q;
  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/display_scan_ctrl.sv
// Converts CHANNELS values to decimal seven-segment digits with one shared engine.
// Results land in a shadow and reach hex/ovf together on the cycle leaving DONE.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int IN_WIDTH = 6,
  parameter int DIGITS   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [CHANNELS*IN_WIDTH-1:0] in,
  input  logic                         lz_en,
  output logic [CHANNELS*DIGITS*7-1:0] hex,
  output logic [CHANNELS-1:0]          ovf,
  output logic                         busy
);

  localparam int ND    = ndig(IN_WIDTH);
  localparam int BCD_W = ND * 4;
  localparam int EXT_W = ((ND > DIGITS) ? ND : DIGITS) * 4 + 4;
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  state_e                       state_q, state_d;
  logic [CH_W-1:0]              ch_q, ch_d;
  logic [CHANNELS*IN_WIDTH-1:0] in_snap_q;
  logic                         lz_snap_q;
  logic [CHANNELS*DIGITS*7-1:0] shadow_q, hex_q;
  logic [CHANNELS-1:0]          sh_ovf_q, ovf_q;

  logic                snap, load, step, store, commit;
  logic [IN_WIDTH-1:0] ch_val;
  logic [BCD_W-1:0]    bcd;
  logic                last;

  assign ch_val = in_snap_q[ch_q*IN_WIDTH +: IN_WIDTH];

  dd_converter #(.IN_WIDTH(IN_WIDTH)) u_dd (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .step_i (step),
    .val_i  (ch_val),
    .bcd_o  (bcd),
    .last_o (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    snap    = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    store   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          snap    = 1'b1;
          ch_d    = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load    = 1'b1;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        step = 1'b1;
        if (last) state_d = ST_STORE;
      end
      ST_STORE: begin
        store = 1'b1;
        if (ch_q == CH_W'(CHANNELS - 1)) begin
          state_d = ST_DONE;
        end else begin
          ch_d    = ch_q + CH_W'(1);
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        commit  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Digit encoding with overflow dashes and leading-zero blanking
  logic [EXT_W-1:0]    bcd_ext;
  logic                enc_ovf;
  logic [DIGITS*7-1:0] enc_seg;
  logic                seen_nz;
  logic [3:0]          nib;

  always_comb begin
    bcd_ext = EXT_W'(bcd);
    enc_ovf = |(bcd_ext >> (DIGITS * 4));
    enc_seg = '0;
    seen_nz = 1'b0;
    nib     = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      nib = bcd_ext[d*4 +: 4];
      if (enc_ovf)                                       enc_seg[d*7 +: 7] = SEG_DASH;
      else if (lz_snap_q && !seen_nz && nib == 4'd0 && d != 0) enc_seg[d*7 +: 7] = SEG_BLANK;
      else                                               enc_seg[d*7 +: 7] = seg_encode(nib);
      if (nib != 4'd0) seen_nz = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q      <= '0;
      in_snap_q <= '0;
      lz_snap_q <= 1'b0;
      shadow_q  <= {(CHANNELS*DIGITS){SEG_BLANK}};
      sh_ovf_q  <= '0;
      hex_q     <= {(CHANNELS*DIGITS){SEG_BLANK}};
      ovf_q     <= '0;
    end else begin
      ch_q <= ch_d;
      if (snap) begin
        in_snap_q <= in;
        lz_snap_q <= lz_en;
      end
      if (store) begin
        shadow_q[ch_q*DIGITS*7 +: DIGITS*7] <= enc_seg;
        sh_ovf_q[ch_q]                      <= enc_ovf;
      end
      if (commit) begin
        hex_q <= shadow_q;
        ovf_q <= sh_ovf_q;
      end
    end
  end

  assign hex  = hex_q;
  assign ovf  = ovf_q;
  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed and model-checked bench for display_scan_ctrl across four parameter sets.
module tb_display_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // A: defaults (2 ch, 6 bit, 2 digits)
  logic        en_a = 0, lz_a = 0, busy_a;
  logic [11:0] in_a = '0;
  logic [27:0] hex_a;
  logic [1:0]  ovf_a;
  // B: 1 ch, 6 bit, 1 digit
  logic        en_b = 0, lz_b = 0, busy_b;
  logic [5:0]  in_b = '0;
  logic [6:0]  hex_b;
  logic [0:0]  ovf_b;
  // C: 3 ch, 10 bit, 3 digits
  logic        en_c = 0, lz_c = 0, busy_c;
  logic [29:0] in_c = '0;
  logic [62:0] hex_c;
  logic [2:0]  ovf_c;
  // D: 1 ch, 1 bit, 1 digit
  logic        en_d = 0, lz_d = 0, busy_d;
  logic [0:0]  in_d = '0;
  logic [6:0]  hex_d;
  logic [0:0]  ovf_d;

  display_scan_ctrl dut_a (.clk(clk), .rst(rst), .en(en_a), .in(in_a), .lz_en(lz_a),
                           .hex(hex_a), .ovf(ovf_a), .busy(busy_a));
  display_scan_ctrl #(.CHANNELS(1), .IN_WIDTH(6), .DIGITS(1)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .in(in_b), .lz_en(lz_b),
    .hex(hex_b), .ovf(ovf_b), .busy(busy_b));
  display_scan_ctrl #(.CHANNELS(3), .IN_WIDTH(10), .DIGITS(3)) dut_c (
    .clk(clk), .rst(rst), .en(en_c), .in(in_c), .lz_en(lz_c),
    .hex(hex_c), .ovf(ovf_c), .busy(busy_c));
  display_scan_ctrl #(.CHANNELS(1), .IN_WIDTH(1), .DIGITS(1)) dut_d (
    .clk(clk), .rst(rst), .en(en_d), .in(in_d), .lz_en(lz_d),
    .hex(hex_d), .ovf(ovf_d), .busy(busy_d));

  function automatic logic [6:0] mdl_seg(input int n);
    case (n)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic logic [20:0] mdl_hex(input int v, input int nd, input bit lz);
    logic [20:0] r;
    int lim, p, dig;
    bit seen;
    r = '0; lim = 1; seen = 0;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    for (int d = nd - 1; d >= 0; d--) begin
      p = 1;
      for (int k = 0; k < d; k++) p = p * 10;
      dig = (v / p) % 10;
      if (v >= lim)                              r[d*7 +: 7] = 7'h3F;
      else if (lz && !seen && dig == 0 && d != 0) r[d*7 +: 7] = 7'h7F;
      else                                       r[d*7 +: 7] = mdl_seg(dig);
      if (dig != 0) seen = 1;
    end
    return r;
  endfunction

  task automatic run_a(input logic [11:0] v, input logic lz, output int cyc);
    @(negedge clk);
    in_a = v; lz_a = lz; en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    cyc = 0;
    while (busy_a && cyc < 200) begin cyc++; @(negedge clk); end
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++; if (hex_a !== {4{7'h7F}}) begin bad++; $display("FAIL reset_hex_a got=%h exp=%h", hex_a, {4{7'h7F}}); end
    total++; if (ovf_a !== 2'b00) begin bad++; $display("FAIL reset_ovf_a got=%b exp=00", ovf_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy_a got=%b exp=0", busy_a); end
    total++; if (hex_c !== {9{7'h7F}}) begin bad++; $display("FAIL reset_hex_c got=%h", hex_c); end
  endtask

  task automatic test_basic;
    int cyc;
    run_a({6'd5, 6'd37}, 1'b1, cyc);
    total++; if (cyc !== 17) begin bad++; $display("FAIL basic_busy_len got=%0d exp=17", cyc); end
    total++; if (hex_a !== {7'h7F, 7'h12, 7'h30, 7'h78}) begin bad++; $display("FAIL basic_hex got=%h exp=%h", hex_a, {7'h7F, 7'h12, 7'h30, 7'h78}); end
    total++; if (ovf_a !== 2'b00) begin bad++; $display("FAIL basic_ovf got=%b exp=00", ovf_a); end
  endtask

  task automatic test_no_blanking;
    int cyc;
    run_a({6'd5, 6'd37}, 1'b0, cyc);
    total++; if (hex_a !== {7'h40, 7'h12, 7'h30, 7'h78}) begin bad++; $display("FAIL nolz_hex got=%h exp=%h", hex_a, {7'h40, 7'h12, 7'h30, 7'h78}); end
  endtask

  task automatic test_zero_max;
    int cyc;
    run_a({6'd63, 6'd0}, 1'b1, cyc);
    total++; if (hex_a !== {7'h02, 7'h30, 7'h7F, 7'h40}) begin bad++; $display("FAIL zero_max_hex got=%h exp=%h", hex_a, {7'h02, 7'h30, 7'h7F, 7'h40}); end
  endtask

  task automatic test_overflow;
    int cyc;
    logic [5:0] vals [2];
    logic [6:0] exp_h [2];
    logic       exp_o [2];
    vals = '{6'd12, 6'd9}; exp_h = '{7'h3F, 7'h10}; exp_o = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_b = vals[i]; lz_b = 1'b1; en_b = 1'b1;
      @(negedge clk);
      en_b = 1'b0; cyc = 0;
      while (busy_b && cyc < 200) begin cyc++; @(negedge clk); end
      total++; if (cyc !== 9) begin bad++; $display("FAIL ovf_busy_len[%0d] got=%0d exp=9", i, cyc); end
      total++; if (hex_b !== exp_h[i]) begin bad++; $display("FAIL ovf_hex[%0d] got=%h exp=%h", i, hex_b, exp_h[i]); end
      total++; if (ovf_b !== exp_o[i]) begin bad++; $display("FAIL ovf_flag[%0d] got=%b exp=%b", i, ovf_b, exp_o[i]); end
    end
  endtask

  task automatic test_snapshot;
    int cyc, extra;
    @(negedge clk);
    in_a = {6'd5, 6'd37}; lz_a = 1'b1; en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0; cyc = 0;
    while (busy_a && cyc < 200) begin
      cyc++;
      if (cyc == 3 || cyc == 10) begin en_a = 1'b1; in_a = {6'd63, 6'd63}; lz_a = 1'b0; end
      if (cyc == 4 || cyc == 11) en_a = 1'b0;
      @(negedge clk);
    end
    total++; if (cyc !== 17) begin bad++; $display("FAIL snap_busy_len got=%0d exp=17", cyc); end
    total++; if (hex_a !== {7'h7F, 7'h12, 7'h30, 7'h78}) begin bad++; $display("FAIL snap_hex got=%h exp=%h", hex_a, {7'h7F, 7'h12, 7'h30, 7'h78}); end
    extra = 0;
    for (int i = 0; i < 4; i++) begin if (busy_a) extra++; @(negedge clk); end
    total++; if (extra !== 0) begin bad++; $display("FAIL snap_no_restart busy_cycles=%0d exp=0", extra); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    @(negedge clk);
    in_a = {6'd63, 6'd63}; lz_a = 1'b0; en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    for (int i = 1; i < 8; i++) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (hex_a !== {4{7'h7F}}) begin bad++; $display("FAIL midrst_hex got=%h exp=%h", hex_a, {4{7'h7F}}); end
    total++; if (ovf_a !== 2'b00) begin bad++; $display("FAIL midrst_ovf got=%b exp=00", ovf_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy_a); end
    @(negedge clk);
    rst = 1'b0;
    run_a({6'd5, 6'd37}, 1'b1, cyc);
    total++; if (hex_a !== {7'h7F, 7'h12, 7'h30, 7'h78}) begin bad++; $display("FAIL midrst_after_hex got=%h exp=%h", hex_a, {7'h7F, 7'h12, 7'h30, 7'h78}); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    @(negedge clk);
    in_a = {6'd0, 6'd42}; lz_a = 1'b1; en_a = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (busy_a && cyc < 200) begin cyc++; @(negedge clk); end
    total++; if (cyc !== 17) begin bad++; $display("FAIL b2b_first_len got=%0d exp=17", cyc); end
    total++; if (hex_a !== {7'h7F, 7'h40, 7'h19, 7'h24}) begin bad++; $display("FAIL b2b_first_hex got=%h exp=%h", hex_a, {7'h7F, 7'h40, 7'h19, 7'h24}); end
    in_a = {6'd10, 6'd1};
    @(negedge clk);
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL b2b_restart busy=%b exp=1", busy_a); end
    en_a = 1'b0; cyc = 1;
    while (busy_a && cyc < 200) begin cyc++; @(negedge clk); end
    total++; if (hex_a !== {7'h79, 7'h40, 7'h7F, 7'h79}) begin bad++; $display("FAIL b2b_second_hex got=%h exp=%h", hex_a, {7'h79, 7'h40, 7'h7F, 7'h79}); end
  endtask

  task automatic test_width1;
    int cyc;
    logic [6:0] exp_h [2];
    exp_h = '{7'h79, 7'h40};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_d = (i == 0) ? 1'b1 : 1'b0; lz_d = 1'b1; en_d = 1'b1;
      @(negedge clk);
      en_d = 1'b0; cyc = 0;
      while (busy_d && cyc < 200) begin cyc++; @(negedge clk); end
      total++; if (cyc !== 4) begin bad++; $display("FAIL w1_busy_len[%0d] got=%0d exp=4", i, cyc); end
      total++; if (hex_d !== exp_h[i] || ovf_d !== 1'b0) begin bad++; $display("FAIL w1_hex[%0d] got=%h/%b exp=%h/0", i, hex_d, ovf_d, exp_h[i]); end
    end
  endtask

  task automatic test_random;
    int cyc, v, unstable;
    logic [62:0] exp_h, prev_h;
    logic [2:0]  exp_o;
    logic [20:0] ch_h;
    logic        lz;
    prev_h = {9{7'h7F}};
    for (int n = 0; n < 500; n++) begin
      lz = 1'($urandom_range(0, 1));
      exp_o = '0;
      for (int c = 0; c < 3; c++) begin
        v = (n % 10 == 0) ? int'($urandom_range(990, 1023)) : int'($urandom_range(0, 1023));
        in_c[c*10 +: 10] = 10'(v);
        ch_h = mdl_hex(v, 3, lz);
        exp_h[c*21 +: 21] = ch_h;
        exp_o[c] = (v >= 1000);
      end
      @(negedge clk);
      lz_c = lz; en_c = 1'b1;
      @(negedge clk);
      en_c = 1'b0; cyc = 0; unstable = 0;
      while (busy_c && cyc < 400) begin
        if (hex_c !== prev_h) unstable++;
        cyc++;
        @(negedge clk);
      end
      total++; if (cyc !== 37) begin bad++; $display("FAIL rand_busy_len[%0d] got=%0d exp=37", n, cyc); end
      total++; if (unstable !== 0) begin bad++; $display("FAIL rand_hex_stable[%0d] changes=%0d exp=0", n, unstable); end
      total++; if (hex_c !== exp_h) begin bad++; $display("FAIL rand_hex[%0d] got=%h exp=%h", n, hex_c, exp_h); end
      total++; if (ovf_c !== exp_o) begin bad++; $display("FAIL rand_ovf[%0d] got=%b exp=%b", n, ovf_c, exp_o); end
      prev_h = exp_h;
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset;
    test_basic;
    test_no_blanking;
    test_zero_max;
    test_overflow;
    test_snapshot;
    test_reset_mid;
    test_back_to_back;
    test_width1;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
